// File: rtl/irq_request_latch.sv
// irq_request_latch: captures rising edges of raw interrupt lines into sticky
// pending bits, applies a per-line mask, and presents a frozen snapshot
// (req_vec/req_valid) to the priority encoder. The snapshot is released by an
// index-based clear handshake.
//
// Optional build macro: IRQ_LATCH_SYNC_EN
//   defined   - each raw line passes through a two-flop synchronizer (reset 1)
//               before edge detection; event-to-req_valid latency is 4 cycles.
//   undefined - raw lines feed edge detection directly; latency is 2 cycles.
// Port lists are identical in both builds.

// Per-line slice: optional synchronizer, edge detect, pending bit and the
// overrun indication for this line.
module irq_request_latch_lane (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic raw,
    input  logic clr_hit,
    output logic pend,
    output logic ovr
);
    logic samp;
    logic prev;
    logic rise;

`ifdef IRQ_LATCH_SYNC_EN
    logic [1:0] sync;

    // Two-flop synchronizer; resets high so a line held high is not an event.
    always_ff @(posedge clk) begin
        if (rst) sync <= 2'b11;
        else     sync <= {sync[0], raw};
    end

    assign samp = sync[1];
`else
    assign samp = raw;
`endif

    // Previous sample tracks the line every cycle, even while disabled, so an
    // edge that happened during en=0 is not replayed when en returns.
    always_ff @(posedge clk) begin
        if (rst) prev <= 1'b1;
        else     prev <= samp;
    end

    assign rise = samp & ~prev;

    // An edge on a line that is already pending and not being cleared now is
    // an overrun; the earlier request is still waiting to be serviced.
    assign ovr = en & rise & pend & ~clr_hit;

    // Pending bit: set on edge, cleared by an accepted clear; set wins.
    always_ff @(posedge clk) begin
        if (rst)     pend <= 1'b0;
        else if (en) pend <= (pend & ~clr_hit) | rise;
    end
endmodule

module irq_request_latch #(
    parameter  int WIDTH = 8,
    parameter  int CNT_W = 8,
    localparam int IDX_W = ($clog2(WIDTH) < 1) ? 1 : $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] irq_raw,
    input  logic [WIDTH-1:0] mask,
    input  logic             clr_valid,
    input  logic [IDX_W-1:0] clr_idx,
    input  logic             clr_sticky,
    output logic [WIDTH-1:0] req_vec,
    output logic             req_valid,
    output logic [WIDTH-1:0] pending,
    output logic             ovf_flag,
    output logic [CNT_W-1:0] ovf_cnt,
    output logic             bad_clr
);
    typedef enum logic [0:0] {
        IDLE    = 1'b0,
        PRESENT = 1'b1
    } state_t;

    typedef struct packed {
        logic             valid;
        logic [IDX_W-1:0] idx;
    } clr_req_t;

    state_t           state, state_nxt;
    clr_req_t         clr;
    logic [WIDTH-1:0] req_vec_q, req_vec_nxt;
    logic [WIDTH-1:0] idx_dec;
    logic [WIDTH-1:0] clr_hit;
    logic [WIDTH-1:0] ovr;
    logic             idx_ok;
    logic             hit_ok;
    logic             clr_acc;
    logic             clr_bad;
    logic             ovr_any;

    assign clr.valid = clr_valid;
    assign clr.idx   = clr_idx;

    // An index outside the line range can exist when WIDTH is not a power of 2.
    assign idx_ok = ({{(32-IDX_W){1'b0}}, clr.idx} < 32'(WIDTH));

    // One-hot decode of the clear index; all zero when the index is out of range.
    always_comb begin
        idx_dec = '0;
        if (idx_ok) idx_dec[clr.idx] = 1'b1;
    end

    // A clear is legal only while presenting and only for a line in the snapshot.
    assign hit_ok  = |(idx_dec & req_vec_q);
    assign clr_acc = en & clr.valid & (state == PRESENT) & hit_ok;
    assign clr_bad = en & clr.valid & ~((state == PRESENT) & hit_ok);
    assign clr_hit = clr_acc ? idx_dec : '0;

    // Per-line edge capture and pending storage.
    for (genvar k = 0; k < WIDTH; k++) begin : g_lane
        irq_request_latch_lane u_lane (
            .clk     (clk),
            .rst     (rst),
            .en      (en),
            .raw     (irq_raw[k]),
            .clr_hit (clr_hit[k]),
            .pend    (pending[k]),
            .ovr     (ovr[k])
        );
    end

    assign ovr_any = |ovr;

    // State and snapshot registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            req_vec_q <= '0;
        end else begin
            state     <= state_nxt;
            req_vec_q <= req_vec_nxt;
        end
    end

    // Next state: snapshot pending&mask from IDLE, hold in PRESENT until an
    // accepted clear; disabling the block drops back to IDLE.
    always_comb begin
        state_nxt   = state;
        req_vec_nxt = req_vec_q;
        if (!en) begin
            state_nxt   = IDLE;
            req_vec_nxt = '0;
        end else begin
            case (state)
                IDLE: begin
                    req_vec_nxt = '0;
                    if (|(pending & mask)) begin
                        state_nxt   = PRESENT;
                        req_vec_nxt = pending & mask;
                    end
                end
                PRESENT: begin
                    if (clr_acc) begin
                        state_nxt   = IDLE;
                        req_vec_nxt = '0;
                    end
                end
                default: begin
                    state_nxt   = IDLE;
                    req_vec_nxt = '0;
                end
            endcase
        end
    end

    assign req_vec   = req_vec_q;
    assign req_valid = (state == PRESENT);

    // Sticky overrun flag and saturating counter; a new overrun beats clr_sticky.
    // Several overruns in one cycle count as one.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_flag <= 1'b0;
            ovf_cnt  <= '0;
        end else if (ovr_any) begin
            ovf_flag <= 1'b1;
            if (ovf_cnt != {CNT_W{1'b1}})
                ovf_cnt <= ovf_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end else if (clr_sticky) begin
            ovf_flag <= 1'b0;
            ovf_cnt  <= '0;
        end
    end

    // Sticky illegal-clear flag; a new illegal clear beats clr_sticky.
    always_ff @(posedge clk) begin
        if (rst)             bad_clr <= 1'b0;
        else if (clr_bad)    bad_clr <= 1'b1;
        else if (clr_sticky) bad_clr <= 1'b0;
    end
endmodule

// File: doc/irq_request_latch.md
Name: irq_request_latch

Overview:
- Sequential front end for the priority encoder stage: captures rising edges on raw interrupt lines into sticky pending bits and applies a per-line mask.
- Presents a held snapshot vector, req_vec, that the encoder consumes on its i input; req_valid drives the encoder's en.
- The snapshot stays frozen while downstream services the winning line, so the encoded index is stable until an index-based clear handshake completes.

Parameters:
- WIDTH, 8, number of interrupt lines; legal range 2..32.
- CNT_W, 8, width of the saturating overrun counter.
- IDX_W, derived as clog2(WIDTH) and minimum 1; width of clr_idx. Not user-overridable.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- en  input  1  block enable.
- irq_raw  input  WIDTH  raw request lines; a 0->1 transition is an event.
- mask  input  WIDTH  1 = line enabled for presentation.
- clr_valid  input  1  downstream acknowledge; single-cycle, always accepted.
- clr_idx  input  IDX_W  index of the line being cleared.
- clr_sticky  input  1  clears ovf_flag, ovf_cnt and bad_clr.
- req_vec  output  WIDTH  held snapshot of pending & mask; feeds encoder i.
- req_valid  output  1  high in PRESENT; feeds encoder en.
- pending  output  WIDTH  raw pending register, for debug.
- ovf_flag  output  1  sticky: an event hit an already-pending line.
- ovf_cnt  output  CNT_W  saturating count of overrun events.
- bad_clr  output  1  sticky: illegal clear observed.

Behaviour:
- Reset values: pending=0, req_vec=0, req_valid=0, ovf_flag=0, ovf_cnt=0, bad_clr=0, state=IDLE. The previous-sample register resets to all ones, so a line already high at reset release is not an event.
- Edge detect: edge[k] = irq_raw[k] & ~prev[k]. prev <= irq_raw every cycle, including when en=0.
- Pending update, with en=1:
  - pending[k] <= (pending[k] & ~clr_hit[k]) | edge[k].
  - clr_hit is the one-hot decode of clr_idx, gated by an accepted clear.
  - When a set and a clear hit the same bit in the same cycle, the set wins.
- Overrun: edge[k] with pending[k]=1 and no clr_hit[k] in that cycle sets ovf_flag and increments ovf_cnt by 1.
  - ovf_cnt saturates at 2^CNT_W-1.
  - Multiple overruns in one cycle add 1 only.
- State machine, two states:
  - IDLE: req_valid=0, req_vec=0. If en=1 and (pending & mask) != 0 at the clock edge: req_vec <= pending & mask, go to PRESENT. Otherwise stay.
  - PRESENT: req_valid=1, req_vec held constant regardless of mask or pending changes. New edges still accumulate in pending. On clr_valid=1, the clear is accepted: pending[clr_idx] is cleared (set wins, as above), req_vec <= 0, go to IDLE.
- Latency:
  - An event sampled at edge T0 sets pending at T0.
  - The snapshot is taken at T1, so req_valid is high after T1.
  - After a clear at Tc, req_valid is low for exactly one cycle. If lines remain pending and unmasked, a re-snapshot occurs at Tc+1.
- Illegal clears set bad_clr; pending and state are unchanged:
  - clr_valid in IDLE.
  - clr_idx >= WIDTH.
  - clr_idx naming a bit that is 0 in req_vec.
- en=0:
  - State is forced to IDLE next cycle; req_vec <= 0, req_valid <= 0.
  - No edges captured and clears ignored; pending and sticky flags are retained.
- clr_sticky=1: ovf_flag, ovf_cnt and bad_clr go to 0 next cycle. An overrun or illegal clear in the same cycle takes priority over clr_sticky.
- rst mid-operation: all state returns to reset values on that edge, regardless of other inputs.

Optional Feature:
- Macro: IRQ_LATCH_SYNC_EN.
- Defined: a two-flop synchronizer per bit (reset value 1) sits ahead of edge detection. Event-to-req_valid latency grows by 2 cycles, from 2 to 4.
- Undefined: irq_raw feeds edge detection directly; latency is 2 cycles.
- Ports are identical in both builds.

Test Plan:
- Reset with irq_raw=8'h01 held, then release -> pending stays 8'h00, req_valid=0.
- mask=8'hFF; pulse irq_raw[5] and irq_raw[2] in the same cycle -> req_vec=8'h24 two cycles later. Then clr_valid with clr_idx=5 -> one cycle with req_valid=0, then req_vec=8'h04.
- In PRESENT with req_vec=8'h04, raise irq_raw[7] -> req_vec stays 8'h04 and pending=8'h84. After clearing index 2 -> next snapshot is 8'h80.
- Pulse irq_raw[3] twice while pending[3]=1 and not cleared -> ovf_cnt=2, ovf_flag=1. Assert clr_sticky -> both read 0.
- Issue clr_valid in IDLE, and clr_idx=6 against req_vec=8'h01 -> bad_clr=1, pending unchanged.
- mask=8'h00 with pending=8'h10 -> stays IDLE. Set mask=8'h10 -> req_valid=1 one cycle later. Drop en -> req_valid=0 next cycle, pending=8'h10 retained.
